// File: rtl/ttw_mem_arb_pkg.sv
// Shared definitions for the translation-walker memory arbiter: default widths,
// source encoding, arbitration pointer states and the request word layout.
package ttw_mem_arb_pkg;

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned MCN_W   = 52;
  localparam int unsigned DAT_W   = 512;
  localparam int unsigned MAX_OUT = 8;

  localparam logic SRC_ILB = 1'b0;
  localparam logic SRC_DLB = 1'b1;

  typedef enum logic {
    RR_ILB = 1'b0,
    RR_DLB = 1'b1
  } rr_e;

  typedef struct packed {
    logic [IDX_W:0]   idx;
    logic [MCN_W-1:0] mcn;
  } mem_req_t;

endpackage

// File: rtl/ttw_out_cnt.sv
// Per-requester outstanding-request counter, bounded to [0, MAX_OUT].
module ttw_out_cnt #(
  parameter int unsigned MAX_OUT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic pend,
  output logic full,
  output logic empty,
  output logic err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_ok, dec_ok;

  // A request parked in the output register is already committed, so it
  // counts toward the limit before it is actually issued.
  assign full  = (cnt_q + CNT_W'(pend)) >= MAX_CNT;
  assign empty = (cnt_q == '0);
  assign err   = dec && empty;

  always_comb begin
    inc_ok = inc && (cnt_q != MAX_CNT);
    dec_ok = dec && !empty;
    cnt_d  = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ttw_mem_arb.sv
// Round-robin arbiter merging ILB and DLB walker line requests onto one memory
// port through a single output register, with combinational response routing.
module ttw_mem_arb #(
  parameter int unsigned IDX_W   = ttw_mem_arb_pkg::IDX_W,
  parameter int unsigned MCN_W   = ttw_mem_arb_pkg::MCN_W,
  parameter int unsigned DAT_W   = ttw_mem_arb_pkg::DAT_W,
  parameter int unsigned MAX_OUT = ttw_mem_arb_pkg::MAX_OUT
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             ilb_req_i_valid,
  output logic             ilb_req_i_ready,
  input  logic [IDX_W-1:0] ilb_req_i_bits_idx,
  input  logic [MCN_W-1:0] ilb_req_i_bits_mcn,

  input  logic             dlb_req_i_valid,
  output logic             dlb_req_i_ready,
  input  logic [IDX_W-1:0] dlb_req_i_bits_idx,
  input  logic [MCN_W-1:0] dlb_req_i_bits_mcn,

  output logic             mem_req_o_valid,
  input  logic             mem_req_o_ready,
  output logic [IDX_W:0]   mem_req_o_bits_idx,
  output logic [MCN_W-1:0] mem_req_o_bits_mcn,

  input  logic             mem_res_i_valid,
  output logic             mem_res_i_ready,
  input  logic [IDX_W:0]   mem_res_i_bits_idx,
  input  logic [DAT_W-1:0] mem_res_i_bits_data,

  output logic             ilb_res_o_valid,
  input  logic             ilb_res_o_ready,
  output logic [IDX_W-1:0] ilb_res_o_bits_idx,
  output logic [DAT_W-1:0] ilb_res_o_bits_data,

  output logic             dlb_res_o_valid,
  input  logic             dlb_res_o_ready,
  output logic [IDX_W-1:0] dlb_res_o_bits_idx,
  output logic [DAT_W-1:0] dlb_res_o_bits_data,

  output logic             busy_o
);

  import ttw_mem_arb_pkg::*;

  rr_e              rr_q, rr_d;
  logic             req_vld_q, req_vld_d;
  logic [IDX_W:0]   req_idx_q, req_idx_d;
  logic [MCN_W-1:0] req_mcn_q, req_mcn_d;

  logic load_ok, ilb_elig, dlb_elig, ilb_gnt, dlb_gnt, ilb_acc, dlb_acc;
  logic mem_fire, req_src, res_src;
  logic ilb_inc, dlb_inc, ilb_dec, dlb_dec, ilb_pend, dlb_pend;
  logic full_i, full_d, empty_i, empty_d, err_i, err_d;

  always_comb begin
    load_ok  = reset && (!req_vld_q || mem_req_o_ready);
    ilb_elig = ilb_req_i_valid && !full_i;
    dlb_elig = dlb_req_i_valid && !full_d;
    ilb_gnt  = ilb_elig && (!dlb_elig || (rr_q == RR_ILB));
    dlb_gnt  = dlb_elig && !ilb_gnt;
    ilb_acc  = load_ok && ilb_gnt;
    dlb_acc  = load_ok && dlb_gnt;
  end

  assign ilb_req_i_ready = ilb_acc;
  assign dlb_req_i_ready = dlb_acc;

  always_comb begin
    rr_d      = rr_q;
    req_vld_d = req_vld_q;
    req_idx_d = req_idx_q;
    req_mcn_d = req_mcn_q;
    if (ilb_acc) begin
      rr_d = RR_DLB;
    end else if (dlb_acc) begin
      rr_d = RR_ILB;
    end
    if (load_ok) begin
      req_vld_d = ilb_acc || dlb_acc;
      if (ilb_acc) begin
        req_idx_d = {SRC_ILB, ilb_req_i_bits_idx};
        req_mcn_d = ilb_req_i_bits_mcn;
      end else if (dlb_acc) begin
        req_idx_d = {SRC_DLB, dlb_req_i_bits_idx};
        req_mcn_d = dlb_req_i_bits_mcn;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q      <= RR_ILB;
      req_vld_q <= 1'b0;
      req_idx_q <= '0;
      req_mcn_q <= '0;
    end else begin
      rr_q      <= rr_d;
      req_vld_q <= req_vld_d;
      req_idx_q <= req_idx_d;
      req_mcn_q <= req_mcn_d;
    end
  end

  assign mem_req_o_valid    = req_vld_q;
  assign mem_req_o_bits_idx = req_idx_q;
  assign mem_req_o_bits_mcn = req_mcn_q;

  always_comb begin
    req_src  = req_idx_q[IDX_W];
    mem_fire = req_vld_q && mem_req_o_ready;
    ilb_inc  = mem_fire && (req_src == SRC_ILB);
    dlb_inc  = mem_fire && (req_src == SRC_DLB);
    ilb_pend = req_vld_q && (req_src == SRC_ILB);
    dlb_pend = req_vld_q && (req_src == SRC_DLB);
  end

  always_comb begin
    res_src             = mem_res_i_bits_idx[IDX_W];
    ilb_res_o_valid     = mem_res_i_valid && (res_src == SRC_ILB);
    dlb_res_o_valid     = mem_res_i_valid && (res_src == SRC_DLB);
    ilb_res_o_bits_idx  = mem_res_i_bits_idx[IDX_W-1:0];
    dlb_res_o_bits_idx  = mem_res_i_bits_idx[IDX_W-1:0];
    ilb_res_o_bits_data = mem_res_i_bits_data;
    dlb_res_o_bits_data = mem_res_i_bits_data;
    mem_res_i_ready     = (res_src == SRC_DLB) ? dlb_res_o_ready : ilb_res_o_ready;
    ilb_dec             = ilb_res_o_valid && ilb_res_o_ready;
    dlb_dec             = dlb_res_o_valid && dlb_res_o_ready;
  end

  ttw_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_i (
    .clock (clock),
    .reset (reset),
    .inc   (ilb_inc),
    .dec   (ilb_dec),
    .pend  (ilb_pend),
    .full  (full_i),
    .empty (empty_i),
    .err   (err_i)
  );

  ttw_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt_d (
    .clock (clock),
    .reset (reset),
    .inc   (dlb_inc),
    .dec   (dlb_dec),
    .pend  (dlb_pend),
    .full  (full_d),
    .empty (empty_d),
    .err   (err_d)
  );

  assign busy_o = req_vld_q || !empty_i || !empty_d;

  // A response for a requester with nothing outstanding is still routed.
  a_res_underflow: assert property (@(posedge clock) disable iff (!reset)
    !(err_i || err_d));

  a_req_stable: assert property (@(posedge clock) disable iff (!reset)
    (mem_req_o_valid && !mem_req_o_ready) |=>
      (mem_req_o_valid && $stable(mem_req_o_bits_idx) && $stable(mem_req_o_bits_mcn)));

endmodule

// File: tb/tb_ttw_mem_arb.sv
// Scoreboard bench for ttw_mem_arb: directed stimulus pushes expected words,
// a negedge monitor pops and compares them on every handshake.
module tb_ttw_mem_arb;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MCN_W   = 52;
  localparam int unsigned DAT_W   = 512;
  localparam int unsigned MAX_OUT = 8;

  typedef struct packed {
    logic [IDX_W:0]   idx;
    logic [MCN_W-1:0] mcn;
  } req_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DAT_W-1:0] data;
  } res_t;

  logic             clock, reset;
  logic             ilb_req_i_valid, ilb_req_i_ready;
  logic [IDX_W-1:0] ilb_req_i_bits_idx;
  logic [MCN_W-1:0] ilb_req_i_bits_mcn;
  logic             dlb_req_i_valid, dlb_req_i_ready;
  logic [IDX_W-1:0] dlb_req_i_bits_idx;
  logic [MCN_W-1:0] dlb_req_i_bits_mcn;
  logic             mem_req_o_valid, mem_req_o_ready;
  logic [IDX_W:0]   mem_req_o_bits_idx;
  logic [MCN_W-1:0] mem_req_o_bits_mcn;
  logic             mem_res_i_valid, mem_res_i_ready;
  logic [IDX_W:0]   mem_res_i_bits_idx;
  logic [DAT_W-1:0] mem_res_i_bits_data;
  logic             ilb_res_o_valid, ilb_res_o_ready;
  logic [IDX_W-1:0] ilb_res_o_bits_idx;
  logic [DAT_W-1:0] ilb_res_o_bits_data;
  logic             dlb_res_o_valid, dlb_res_o_ready;
  logic [IDX_W-1:0] dlb_res_o_bits_idx;
  logic [DAT_W-1:0] dlb_res_o_bits_data;
  logic             busy_o;

  req_t exp_req_q[$];
  res_t exp_ilb_q[$];
  res_t exp_dlb_q[$];
  req_t mon_req;
  res_t mon_res;
  int   checks = 0;
  int   errors = 0;

  ttw_mem_arb #(.IDX_W(IDX_W), .MCN_W(MCN_W), .DAT_W(DAT_W), .MAX_OUT(MAX_OUT)) dut (
    .clock               (clock),
    .reset               (reset),
    .ilb_req_i_valid     (ilb_req_i_valid),
    .ilb_req_i_ready     (ilb_req_i_ready),
    .ilb_req_i_bits_idx  (ilb_req_i_bits_idx),
    .ilb_req_i_bits_mcn  (ilb_req_i_bits_mcn),
    .dlb_req_i_valid     (dlb_req_i_valid),
    .dlb_req_i_ready     (dlb_req_i_ready),
    .dlb_req_i_bits_idx  (dlb_req_i_bits_idx),
    .dlb_req_i_bits_mcn  (dlb_req_i_bits_mcn),
    .mem_req_o_valid     (mem_req_o_valid),
    .mem_req_o_ready     (mem_req_o_ready),
    .mem_req_o_bits_idx  (mem_req_o_bits_idx),
    .mem_req_o_bits_mcn  (mem_req_o_bits_mcn),
    .mem_res_i_valid     (mem_res_i_valid),
    .mem_res_i_ready     (mem_res_i_ready),
    .mem_res_i_bits_idx  (mem_res_i_bits_idx),
    .mem_res_i_bits_data (mem_res_i_bits_data),
    .ilb_res_o_valid     (ilb_res_o_valid),
    .ilb_res_o_ready     (ilb_res_o_ready),
    .ilb_res_o_bits_idx  (ilb_res_o_bits_idx),
    .ilb_res_o_bits_data (ilb_res_o_bits_data),
    .dlb_res_o_valid     (dlb_res_o_valid),
    .dlb_res_o_ready     (dlb_res_o_ready),
    .dlb_res_o_bits_idx  (dlb_res_o_bits_idx),
    .dlb_res_o_bits_data (dlb_res_o_bits_data),
    .busy_o              (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DAT_W-1:0] pat(input logic [31:0] seed);
    return {16{seed}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push_req(input logic src, input logic [IDX_W-1:0] idx, input logic [MCN_W-1:0] mcn);
    exp_req_q.push_back({src, idx, mcn});
  endtask

  task automatic send_res(input logic src, input logic [IDX_W-1:0] idx, input logic [31:0] seed);
    if (src) exp_dlb_q.push_back({idx, pat(seed)});
    else     exp_ilb_q.push_back({idx, pat(seed)});
    mem_res_i_valid     = 1'b1;
    mem_res_i_bits_idx  = {src, idx};
    mem_res_i_bits_data = pat(seed);
    cyc();
    mem_res_i_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mem_req_o_valid && mem_req_o_ready) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req_extra: got idx %0h mcn %0h, required no request", mem_req_o_bits_idx, mem_req_o_bits_mcn);
      end else begin
        mon_req = exp_req_q.pop_front();
        if (mem_req_o_bits_idx !== mon_req.idx || mem_req_o_bits_mcn !== mon_req.mcn) begin
          errors++;
          $display("FAIL mem_req: got idx %0h mcn %0h, required idx %0h mcn %0h",
                   mem_req_o_bits_idx, mem_req_o_bits_mcn, mon_req.idx, mon_req.mcn);
        end
      end
    end
    if (ilb_res_o_valid && ilb_res_o_ready) begin
      checks++;
      if (exp_ilb_q.size() == 0) begin
        errors++;
        $display("FAIL ilb_res_extra: got idx %0h, required no response", ilb_res_o_bits_idx);
      end else begin
        mon_res = exp_ilb_q.pop_front();
        if (ilb_res_o_bits_idx !== mon_res.idx || ilb_res_o_bits_data !== mon_res.data) begin
          errors++;
          $display("FAIL ilb_res: got idx %0h data %0h, required idx %0h data %0h",
                   ilb_res_o_bits_idx, ilb_res_o_bits_data[63:0], mon_res.idx, mon_res.data[63:0]);
        end
      end
    end
    if (dlb_res_o_valid && dlb_res_o_ready) begin
      checks++;
      if (exp_dlb_q.size() == 0) begin
        errors++;
        $display("FAIL dlb_res_extra: got idx %0h, required no response", dlb_res_o_bits_idx);
      end else begin
        mon_res = exp_dlb_q.pop_front();
        if (dlb_res_o_bits_idx !== mon_res.idx || dlb_res_o_bits_data !== mon_res.data) begin
          errors++;
          $display("FAIL dlb_res: got idx %0h data %0h, required idx %0h data %0h",
                   dlb_res_o_bits_idx, dlb_res_o_bits_data[63:0], mon_res.idx, mon_res.data[63:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset               = 1'b0;
    ilb_req_i_valid     = 1'b1;
    ilb_req_i_bits_idx  = '0;
    ilb_req_i_bits_mcn  = '0;
    dlb_req_i_valid     = 1'b1;
    dlb_req_i_bits_idx  = '0;
    dlb_req_i_bits_mcn  = '0;
    mem_req_o_ready     = 1'b0;
    mem_res_i_valid     = 1'b0;
    mem_res_i_bits_idx  = '0;
    mem_res_i_bits_data = '0;
    ilb_res_o_ready     = 1'b1;
    dlb_res_o_ready     = 1'b1;

    // reset state, requesters valid during reset
    #3;
    chk("rst_mem_valid", mem_req_o_valid, 0);
    chk("rst_ilb_ready", ilb_req_i_ready, 0);
    chk("rst_dlb_ready", dlb_req_i_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ilb_res_valid", ilb_res_o_valid, 0);
    chk("rst_dlb_res_valid", dlb_res_o_valid, 0);
    ilb_req_i_valid = 1'b0;
    dlb_req_i_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // both valid, full throughput: alternating grants, ILB first
    ilb_req_i_bits_idx = 5'h11; ilb_req_i_bits_mcn = 52'hA_0011;
    dlb_req_i_bits_idx = 5'h02; dlb_req_i_bits_mcn = 52'hD_0022;
    ilb_req_i_valid = 1'b1; dlb_req_i_valid = 1'b1; mem_req_o_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_req(1'b0, ilb_req_i_bits_idx, ilb_req_i_bits_mcn);
      else            push_req(1'b1, dlb_req_i_bits_idx, dlb_req_i_bits_mcn);
      settle();
      chk("alt_ilb_ready", ilb_req_i_ready, (k % 2 == 0));
      chk("alt_dlb_ready", dlb_req_i_ready, (k % 2 == 1));
      cyc();
    end
    ilb_req_i_valid = 1'b0; dlb_req_i_valid = 1'b0;
    cyc();
    settle();
    chk("alt_busy", busy_o, 1);

    // response routing to DLB, backpressure from dlb_res_o_ready
    dlb_res_o_ready     = 1'b0;
    mem_res_i_valid     = 1'b1;
    mem_res_i_bits_idx  = 6'h2A;
    mem_res_i_bits_data = pat(32'hCAFE_0001);
    settle();
    chk("route_dlb_valid", dlb_res_o_valid, 1);
    chk("route_dlb_idx", dlb_res_o_bits_idx, 5'h0A);
    chk("route_ilb_valid", ilb_res_o_valid, 0);
    chk("route_res_ready_bp", mem_res_i_ready, 0);
    checks++;
    if (dlb_res_o_bits_data !== pat(32'hCAFE_0001)) begin
      errors++;
      $display("FAIL route_dlb_data: got %0h, required %0h", dlb_res_o_bits_data, pat(32'hCAFE_0001));
    end
    cyc();
    dlb_res_o_ready = 1'b1;
    exp_dlb_q.push_back({5'h0A, pat(32'hCAFE_0001)});
    settle();
    chk("route_res_ready", mem_res_i_ready, 1);
    cyc();
    mem_res_i_valid = 1'b0;
    for (int k = 0; k < 3; k++) send_res(1'b0, 5'h11, 32'h1100_0000 + k);
    for (int k = 0; k < 2; k++) send_res(1'b1, 5'h02, 32'h0200_0000 + k);
    settle();
    chk("drain_busy", busy_o, 0);

    // stall: word held for 5 cycles, nothing accepted, fires on the 6th
    mem_req_o_ready = 1'b0;
    ilb_req_i_valid = 1'b1; ilb_req_i_bits_idx = 5'h05; ilb_req_i_bits_mcn = 52'h123;
    push_req(1'b0, 5'h05, 52'h123);
    settle();
    chk("stall_accept", ilb_req_i_ready, 1);
    cyc();
    ilb_req_i_bits_idx = 5'h07; ilb_req_i_bits_mcn = 52'h999;
    dlb_req_i_valid = 1'b1; dlb_req_i_bits_idx = 5'h09; dlb_req_i_bits_mcn = 52'h888;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_valid", mem_req_o_valid, 1);
      chk("stall_idx", mem_req_o_bits_idx, 6'h05);
      chk("stall_mcn", mem_req_o_bits_mcn, 52'h123);
      chk("stall_ilb_ready", ilb_req_i_ready, 0);
      chk("stall_dlb_ready", dlb_req_i_ready, 0);
      cyc();
    end
    ilb_req_i_valid = 1'b0; dlb_req_i_valid = 1'b0; mem_req_o_ready = 1'b1;
    settle();
    chk("stall_fire_valid", mem_req_o_valid, 1);
    cyc();
    settle();
    chk("stall_empty", mem_req_o_valid, 0);
    send_res(1'b0, 5'h05, 32'h0500_0000);

    // DLB outstanding limit: 8 accepted, 9th refused while ILB still served
    dlb_req_i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dlb_req_i_bits_idx = IDX_W'(k);
      dlb_req_i_bits_mcn = MCN_W'(32'h100 + k);
      push_req(1'b1, IDX_W'(k), MCN_W'(32'h100 + k));
      settle();
      chk("lim_dlb_ready", dlb_req_i_ready, 1);
      cyc();
    end
    dlb_req_i_bits_idx = 5'h08; dlb_req_i_bits_mcn = 52'h108;
    ilb_req_i_valid = 1'b1; ilb_req_i_bits_idx = 5'h15; ilb_req_i_bits_mcn = 52'h777;
    push_req(1'b0, 5'h15, 52'h777);
    settle();
    chk("lim_9th_dlb_ready", dlb_req_i_ready, 0);
    chk("lim_ilb_ready", ilb_req_i_ready, 1);
    cyc();
    ilb_req_i_valid = 1'b0;
    settle();
    chk("lim_full_dlb_ready", dlb_req_i_ready, 0);
    cyc();
    exp_dlb_q.push_back({5'h00, pat(32'hD000_0000)});
    mem_res_i_valid = 1'b1; mem_res_i_bits_idx = 6'h20; mem_res_i_bits_data = pat(32'hD000_0000);
    settle();
    chk("lim_res_cycle_ready", dlb_req_i_ready, 0);
    cyc();
    mem_res_i_valid = 1'b0;
    push_req(1'b1, 5'h08, 52'h108);
    settle();
    chk("lim_resume_ready", dlb_req_i_ready, 1);
    cyc();
    dlb_req_i_valid = 1'b0;
    cyc();

    // drain to cnt_i = 0, cnt_d = 3
    send_res(1'b0, 5'h15, 32'h1500_0000);
    for (int k = 1; k < 6; k++) send_res(1'b1, IDX_W'(k), 32'hD000_0000 + k);

    // same-cycle DLB issue and DLB response leaves the count at 3
    dlb_req_i_valid = 1'b1; dlb_req_i_bits_idx = 5'h1F; dlb_req_i_bits_mcn = 52'hABC;
    push_req(1'b1, 5'h1F, 52'hABC);
    settle();
    chk("same_dlb_ready", dlb_req_i_ready, 1);
    cyc();
    dlb_req_i_valid = 1'b0;
    exp_dlb_q.push_back({5'h06, pat(32'hD000_0006)});
    mem_res_i_valid = 1'b1; mem_res_i_bits_idx = 6'h26; mem_res_i_bits_data = pat(32'hD000_0006);
    settle();
    chk("same_fire", mem_req_o_valid, 1);
    chk("same_res_ready", mem_res_i_ready, 1);
    cyc();
    mem_res_i_valid = 1'b0;
    send_res(1'b1, 5'h07, 32'hD000_0007);
    settle();
    chk("same_busy_2", busy_o, 1);
    send_res(1'b1, 5'h08, 32'hD000_0008);
    settle();
    chk("same_busy_1", busy_o, 1);
    send_res(1'b1, 5'h1F, 32'hD000_001F);
    settle();
    chk("same_busy_0", busy_o, 0);

    // reset with two outstanding ILB requests and a stalled DLB word
    ilb_req_i_valid = 1'b1; ilb_req_i_bits_idx = 5'h01; ilb_req_i_bits_mcn = 52'h1;
    push_req(1'b0, 5'h01, 52'h1);
    cyc();
    ilb_req_i_bits_idx = 5'h02; ilb_req_i_bits_mcn = 52'h2;
    push_req(1'b0, 5'h02, 52'h2);
    cyc();
    ilb_req_i_valid = 1'b0;
    dlb_req_i_valid = 1'b1; dlb_req_i_bits_idx = 5'h03; dlb_req_i_bits_mcn = 52'h3;
    cyc();
    dlb_req_i_valid = 1'b0; mem_req_o_ready = 1'b0;
    settle();
    chk("prerst_valid", mem_req_o_valid, 1);
    chk("prerst_busy", busy_o, 1);
    ilb_req_i_valid = 1'b1; dlb_req_i_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_valid", mem_req_o_valid, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ilb_ready", ilb_req_i_ready, 0);
    chk("midrst_dlb_ready", dlb_req_i_ready, 0);
    ilb_req_i_valid = 1'b0; dlb_req_i_valid = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("postrst_busy", busy_o, 0);
    cyc();
    ilb_req_i_valid = 1'b1; ilb_req_i_bits_idx = 5'h0C; ilb_req_i_bits_mcn = 52'hC;
    dlb_req_i_valid = 1'b1; dlb_req_i_bits_idx = 5'h0D; dlb_req_i_bits_mcn = 52'hD;
    mem_req_o_ready = 1'b1;
    push_req(1'b0, 5'h0C, 52'hC);
    settle();
    chk("postrst_ilb_first", ilb_req_i_ready, 1);
    chk("postrst_dlb_wait", dlb_req_i_ready, 0);
    cyc();
    push_req(1'b1, 5'h0D, 52'hD);
    settle();
    chk("postrst_dlb_next", dlb_req_i_ready, 1);
    cyc();
    ilb_req_i_valid = 1'b0; dlb_req_i_valid = 1'b0;
    cyc();
    cyc();

    chk("req_queue_empty", exp_req_q.size(), 0);
    chk("ilb_queue_empty", exp_ilb_q.size(), 0);
    chk("dlb_queue_empty", exp_dlb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
